perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of pipeline event counters. It replaces the fixed four-counter block
//  (total / jump / taken-branch / load-use) in the CPU top level.
//  - Counts NUM_CH event lines: cycles, jumps, branches, stalls, flushes, etc.
//  - Each channel counts either levels or rising edges; counters wrap or saturate.
//  - Overflow flags are sticky, with a snapshot copy and a registered readout port for the
//    display path.
//  - A halt (syscall stop) freezes the bank until it is cleared.
// PARAMETERS
//  NUM_CH     8         number of event channels (2..32)
//  CNT_W      32        counter width in bits (8..64)
//  SAT        0         0 = counters wrap to 0 on overflow; 1 = counters saturate at all-ones
//  EDGE_MASK  8'h00     bit i = 1: channel i counts 0->1 edges of evt[i]; bit i = 0: counts cycles evt[i] is high
//  SEL_W      $clog2(NUM_CH)  width of the channel select
// PORTS
//  clk        in   1          system clock; all state changes on the rising edge
//  in_RST     in   1          synchronous, active-high reset
//  en         in   1          pipeline enable; counting is gated while en = 0
//  halt       in   1          one-cycle pulse from syscall halt; freezes the bank
//  evt        in   NUM_CH     event lines, sampled each clock
//  clr        in   1          synchronous clear of all counters, flags and snapshots; un-freezes the bank
//  snap       in   1          copy all live counters into the snapshot registers
//  sel        in   SEL_W      readout channel select
//  rd_snap    in   1          readout source: 1 = snapshot, 0 = live counter
//  data_out   out  CNT_W      registered readout of the selected counter
//  ovf        out  NUM_CH     sticky per-channel overflow flags
//  frozen     out  1          1 while in state FROZEN
// BEHAVIOUR
//  Reset (in_RST = 1 at an edge):
//   - all counters, snapshots, ovf, data_out and the edge-history register go to 0;
//   - state goes to RUN; frozen = 0.
//  State machine:
//   - RUN: halt = 1 moves to FROZEN.
//   - FROZEN: counters hold; only clr or in_RST returns to RUN.
//   - halt while already FROZEN has no effect.
//  Per-channel increment condition (inc_i):
//   - requires state RUN, en = 1, and no clr;
//   - level channel: evt[i] = 1;
//   - edge channel: evt[i] = 1 and prev[i] = 0.
//  Edge history: prev[i] <= evt[i] every cycle the bank is not in reset, including stalls and
//   FROZEN. An edge that falls inside a stall is therefore lost, not deferred.
//  Counter update when inc_i = 1:
//   - counter below all-ones: cnt <= cnt + 1.
//   - counter at all-ones: ovf[i] <= 1; cnt <= 0 if SAT = 0, else cnt holds all-ones.
//  ovf[i] stays set until clr or in_RST.
//  Priority: in_RST > clr > halt > counting. halt and inc in the same cycle: that cycle's
//   increment does not occur, since the freeze takes effect immediately.
//  clr: counters, snapshots and ovf go to 0 on the next edge; state goes to RUN; prev is still updated.
//  snap: all snapshots take the pre-increment value of their counters at the same edge.
//   - snap and clr together: the snapshot captures 0.
//   - snap is honoured in FROZEN and during en = 0.
//  Readout latency: data_out <= (rd_snap ? snapshot[sel] : cnt[sel]), one cycle after sel and rd_snap.
//   - the value reflects state before the current edge's update;
//   - sel >= NUM_CH reads 0.
//  No combinational path from any input to any output.
// TESTING
//  1. Reset, then evt = 8'h01 (level), en = 1 for 10 cycles
//     -> cnt[0] = 10, others 0; data_out = 10 one cycle after sel = 0.
//  2. EDGE_MASK bit 1 set; evt[1] toggles 1,0,1,0,1 with en = 1; a 3-cycle en = 0 stall holding evt[1] = 1
//     -> cnt[1] = 3; the stall adds nothing.
//  3. CNT_W = 8 with SAT = 0, then SAT = 1; evt[2] high for 260 cycles
//     -> wrap: cnt = 4, ovf[2] = 1; sat: cnt = 255, ovf[2] = 1.
//  4. Counting cnt[0] = 5; halt pulse together with evt[0] = 1
//     -> cnt[0] stays 5, frozen = 1, 20 further cycles change nothing.
//     -> clr then returns frozen = 0 and all counts to 0.
//  5. cnt[3] = 7 and evt[3] = 1 with snap = 1
//     -> snapshot[3] = 7, live = 8; rd_snap = 1, sel = 3 returns 7.
//     -> snap with clr together returns snapshot 0.
//  6. in_RST asserted mid-count with ovf set and FROZEN
//     -> the next edge shows all outputs 0, frozen = 0; counting resumes the following cycle.

Source files
------------

// File: rtl/perf_counter_bank_if.sv
// rtl/perf_counter_bank_if.sv - control, event and readout bundle of the performance counter bank
//
// Purpose: groups every non-clock/non-reset signal of perf_counter_bank.
// Ports (master = pipeline/display side, slave = counter bank):
//   en        m->s  pipeline enable, gates counting
//   halt      m->s  one-cycle syscall-halt pulse, freezes the bank
//   evt       m->s  NUM_CH event lines
//   clr       m->s  clear counters, flags, snapshots; un-freezes
//   snap      m->s  copy live counters into snapshots
//   sel       m->s  readout channel select
//   rd_snap   m->s  readout source (1 = snapshot, 0 = live)
//   data_out  s->m  registered readout
//   ovf       s->m  sticky overflow flags
//   frozen    s->m  bank is frozen
interface perf_counter_bank_if #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic              en;
    logic              halt;
    logic [NUM_CH-1:0] evt;
    logic              clr;
    logic              snap;
    logic [SEL_W-1:0]  sel;
    logic              rd_snap;
    logic [CNT_W-1:0]  data_out;
    logic [NUM_CH-1:0] ovf;
    logic              frozen;

    modport master (
        output en, halt, evt, clr, snap, sel, rd_snap,
        input  data_out, ovf, frozen
    );

    modport slave (
        input  en, halt, evt, clr, snap, sel, rd_snap,
        output data_out, ovf, frozen
    );
endinterface

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - parametrised bank of pipeline event counters
//
// Purpose: counts NUM_CH event lines (level or rising-edge per channel), with
// wrap or saturate on overflow, sticky overflow flags, snapshot registers, a
// registered readout port and a halt-triggered freeze.
// Ports:
//   clk     in   system clock, rising edge
//   in_RST  in   synchronous active-high reset
//   bus     slave modport of perf_counter_bank_if (controls, events, readout)
module perf_counter_bank #(
    parameter int                NUM_CH    = 8,
    parameter int                CNT_W     = 32,
    parameter int                SAT       = 0,
    parameter logic [NUM_CH-1:0] EDGE_MASK = '0,
    parameter int                SEL_W     = $clog2(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 in_RST,
    perf_counter_bank_if.slave   bus
);
    typedef enum logic {S_RUN = 1'b0, S_FROZEN = 1'b1} state_t;

    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_count_ok;
    logic              w_frozen;
    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] w_inc;
    logic [CNT_W-1:0]  r_cnt  [NUM_CH];
    logic [CNT_W-1:0]  r_snap [NUM_CH];
    logic [CNT_W-1:0]  r_data_out;
    logic [CNT_W-1:0]  w_rd;

    // Next state and count gating. halt suppresses the same-cycle increment
    // because the freeze is considered effective immediately.
    always_comb begin
        w_state_nxt = r_state;
        w_count_ok  = 1'b0;
        w_frozen    = 1'b0;
        case (r_state)
            S_RUN: begin
                w_count_ok = bus.en && !bus.clr && !bus.halt;
                if (!bus.clr && bus.halt) begin
                    w_state_nxt = S_FROZEN;
                end
            end
            S_FROZEN: begin
                w_frozen = 1'b1;
                if (bus.clr) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    // Edge channels need a 0->1 transition against the history register,
    // which tracks evt even while stalled, so stalled edges are dropped.
    always_comb begin
        w_inc = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_inc[i] = w_count_ok && bus.evt[i] && (!EDGE_MASK[i] || !r_prev[i]);
        end
    end

    // Readout mux; selects beyond the last channel read zero.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(bus.sel) == i) begin
                w_rd = bus.rd_snap ? r_snap[i] : r_cnt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_RST) begin
            r_state    <= S_RUN;
            r_prev     <= '0;
            r_ovf      <= '0;
            r_data_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_prev     <= bus.evt;
            r_data_out <= w_rd;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.clr) begin
                    r_cnt[i]  <= '0;
                    r_snap[i] <= '0;
                    r_ovf[i]  <= 1'b0;
                end else begin
                    // snapshot takes the pre-increment value
                    if (bus.snap) begin
                        r_snap[i] <= r_cnt[i];
                    end
                    if (w_inc[i]) begin
                        if (r_cnt[i] == ALL_ONES) begin
                            r_ovf[i] <= 1'b1;
                            if (SAT == 0) begin
                                r_cnt[i] <= '0;
                            end
                        end else begin
                            r_cnt[i] <= r_cnt[i] + ONE;
                        end
                    end
                end
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.ovf      = r_ovf;
    assign bus.frozen   = w_frozen;
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank (wrap and saturate instances)
module tb_perf_counter_bank;
    localparam int         NCH = 6;
    localparam int         CW  = 8;
    localparam logic [5:0] EM  = 6'b100010;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       t_en = 1'b0, t_halt = 1'b0, t_clr = 1'b0, t_snap = 1'b0, t_rd_snap = 1'b0;
    logic [5:0] t_evt = '0;
    logic [2:0] t_sel = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perf_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_a ();
    perf_counter_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_b ();

    assign bus_a.en = t_en;   assign bus_b.en = t_en;
    assign bus_a.halt = t_halt; assign bus_b.halt = t_halt;
    assign bus_a.evt = t_evt; assign bus_b.evt = t_evt;
    assign bus_a.clr = t_clr; assign bus_b.clr = t_clr;
    assign bus_a.snap = t_snap; assign bus_b.snap = t_snap;
    assign bus_a.sel = t_sel; assign bus_b.sel = t_sel;
    assign bus_a.rd_snap = t_rd_snap; assign bus_b.rd_snap = t_rd_snap;

    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SAT(0), .EDGE_MASK(EM)) dut_a (
        .clk(clk), .in_RST(rst), .bus(bus_a.slave));
    perf_counter_bank #(.NUM_CH(NCH), .CNT_W(CW), .SAT(1), .EDGE_MASK(EM)) dut_b (
        .clk(clk), .in_RST(rst), .bus(bus_b.slave));

    // Reference model: index 0 = wrapping instance, 1 = saturating instance.
    int   m_cnt  [2][NCH];
    int   m_snap [2][NCH];
    bit   m_ovf  [2][NCH];
    int   m_dout [2];
    bit   m_prev [NCH];
    bit   m_frozen;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
        end
    endtask

    function automatic logic [5:0] ovf_vec(input int d);
        logic [5:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[d][i];
        return v;
    endfunction

    task automatic model_edge();
        bit counting;
        for (int d = 0; d < 2; d++) begin
            if (int'(t_sel) < NCH)
                m_dout[d] = t_rd_snap ? m_snap[d][t_sel] : m_cnt[d][t_sel];
            else
                m_dout[d] = 0;
        end
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_dout[d] = 0;
                for (int i = 0; i < NCH; i++) begin
                    m_cnt[d][i] = 0; m_snap[d][i] = 0; m_ovf[d][i] = 0;
                end
            end
            for (int i = 0; i < NCH; i++) m_prev[i] = 0;
            m_frozen = 0;
            return;
        end
        counting = !m_frozen && t_en && !t_clr && !t_halt;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NCH; i++) begin
                if (t_clr) begin
                    m_cnt[d][i] = 0; m_snap[d][i] = 0; m_ovf[d][i] = 0;
                end else begin
                    if (t_snap) m_snap[d][i] = m_cnt[d][i];
                    if (counting && t_evt[i] && !(EM[i] && m_prev[i])) begin
                        if (m_cnt[d][i] == 255) begin
                            m_ovf[d][i] = 1;
                            m_cnt[d][i] = (d == 0) ? 0 : 255;
                        end else begin
                            m_cnt[d][i] = m_cnt[d][i] + 1;
                        end
                    end
                end
            end
        end
        if (t_clr) m_frozen = 0;
        else if (t_halt) m_frozen = 1;
        for (int i = 0; i < NCH; i++) m_prev[i] = t_evt[i];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("dout_wrap", 64'(bus_a.data_out), 64'(m_dout[0]));
        check_eq("dout_sat",  64'(bus_b.data_out), 64'(m_dout[1]));
        check_eq("ovf_wrap",  64'(bus_a.ovf), 64'(ovf_vec(0)));
        check_eq("ovf_sat",   64'(bus_b.ovf), 64'(ovf_vec(1)));
        check_eq("frozen_wrap", 64'(bus_a.frozen), 64'(m_frozen));
        check_eq("frozen_sat",  64'(bus_b.frozen), 64'(m_frozen));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_clr();
        t_clr = 1'b1; t_evt = '0; tick(); t_clr = 1'b0;
    endtask

    task automatic read(input logic [2:0] s, input logic rs);
        t_evt = '0; t_sel = s; t_rd_snap = rs; tick();
    endtask

    initial begin
        // reset
        rst = 1'b1; tick();
        check_eq("rst_dout", 64'(bus_a.data_out), 64'd0);
        check_eq("rst_ovf", 64'(bus_a.ovf), 64'd0);
        check_eq("rst_frozen", 64'(bus_b.frozen), 64'd0);
        rst = 1'b0;

        // level counting on channel 0
        t_en = 1'b1; t_evt = 6'h01; ticks(10);
        read(3'd0, 1'b0);
        check_eq("lvl_cnt0", 64'(bus_a.data_out), 64'd10);
        read(3'd1, 1'b0);
        check_eq("lvl_cnt1", 64'(bus_a.data_out), 64'd0);

        // edge channel 1 with a stall
        do_clr();
        t_evt = 6'h02; tick(); t_evt = 6'h00; tick();
        t_evt = 6'h02; tick(); t_evt = 6'h00; tick();
        t_evt = 6'h02; tick(); t_evt = 6'h00; tick();
        t_en = 1'b0; t_evt = 6'h02; ticks(3);
        t_en = 1'b1; ticks(2);
        read(3'd1, 1'b0);
        check_eq("edge_cnt1", 64'(bus_a.data_out), 64'd3);

        // wrap vs saturate
        do_clr();
        t_evt = 6'h04; ticks(260);
        read(3'd2, 1'b0);
        check_eq("wrap_cnt2", 64'(bus_a.data_out), 64'd4);
        check_eq("sat_cnt2", 64'(bus_b.data_out), 64'd255);
        check_eq("wrap_ovf2", 64'(bus_a.ovf[2]), 64'd1);
        check_eq("sat_ovf2", 64'(bus_b.ovf[2]), 64'd1);

        // halt freezes
        do_clr();
        t_evt = 6'h01; ticks(5);
        t_halt = 1'b1; tick(); t_halt = 1'b0;
        check_eq("halt_frozen", 64'(bus_a.frozen), 64'd1);
        t_evt = 6'h3f; ticks(20);
        read(3'd0, 1'b0);
        check_eq("halt_cnt0", 64'(bus_a.data_out), 64'd5);
        do_clr();
        check_eq("clr_frozen", 64'(bus_a.frozen), 64'd0);
        read(3'd0, 1'b0);
        check_eq("clr_cnt0", 64'(bus_a.data_out), 64'd0);

        // snapshot
        t_evt = 6'h08; ticks(7);
        t_snap = 1'b1; tick(); t_snap = 1'b0;
        read(3'd3, 1'b1);
        check_eq("snap3", 64'(bus_a.data_out), 64'd7);
        read(3'd3, 1'b0);
        check_eq("live3", 64'(bus_a.data_out), 64'd8);
        t_snap = 1'b1; t_clr = 1'b1; tick(); t_snap = 1'b0; t_clr = 1'b0;
        read(3'd3, 1'b1);
        check_eq("snap_clr3", 64'(bus_a.data_out), 64'd0);
        read(3'd7, 1'b0);
        check_eq("sel_oob", 64'(bus_b.data_out), 64'd0);

        // reset while frozen with overflow set
        t_evt = 6'h04; t_sel = 3'd2; ticks(260);
        t_halt = 1'b1; tick(); t_halt = 1'b0;
        check_eq("pre_rst_frozen", 64'(bus_a.frozen), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("rst2_dout", 64'(bus_b.data_out), 64'd0);
        check_eq("rst2_ovf", 64'(bus_b.ovf), 64'd0);
        check_eq("rst2_frozen", 64'(bus_a.frozen), 64'd0);
        t_evt = 6'h01; tick();
        read(3'd0, 1'b0);
        check_eq("resume_cnt0", 64'(bus_a.data_out), 64'd1);

        // randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            rst       = ($urandom_range(0, 299) == 0);
            t_clr     = ($urandom_range(0, 39) == 0);
            t_halt    = ($urandom_range(0, 39) == 0);
            t_snap    = ($urandom_range(0, 9) == 0);
            t_en      = ($urandom_range(0, 4) != 0);
            t_evt     = 6'($urandom);
            t_sel     = 3'($urandom);
            t_rd_snap = 1'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
